prog_loader: RTL and testbench
==============================

# prog_loader

Program loader that writes the instruction ROM/RAM that the core's control logic fetches from. It accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive addresses from 0. It zero-fills the unused remainder of the address space and holds the core in reset until the image is complete. It sits between the host/debug input and the instruction memory write port, and drives the core's reset.

## Interface
- BIT_WIDTH, 4, datapath and program-counter width; memory depth DEPTH = 2**BIT_WIDTH
- INST_WIDTH, BIT_WIDTH + 4, instruction word width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- len  input  BIT_WIDTH+1  number of words to load; sampled with start; legal range 1..DEPTH
- in_data  input  INST_WIDTH  instruction word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  BIT_WIDTH  memory write address
- wr_data  output  INST_WIDTH  memory write data
- cpu_rst  output  1  reset to core; high while no valid image is loaded
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on load completion
- err  output  1  sticky: last start carried an illegal len
- checksum  output  INST_WIDTH  sum of accepted words, modulo 2**INST_WIDTH

## Operation
- States: IDLE, LOAD, FILL, DONE. busy = (state != IDLE). done = (state == DONE). in_ready = (state == LOAD).
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_rst 1, busy 0, done 0, err 0, checksum 0.
- IDLE, start=1, 1 <= len <= DEPTH:
  - go to LOAD.
  - Latch len.
  - Clear word counter, checksum and err.
  - Set cpu_rst=1.
- IDLE, start=1, len=0 or len>DEPTH:
  - Set err=1 and stay IDLE.
  - No writes; cpu_rst unchanged.
- LOAD: a handshake is in_valid && in_ready. Each handshake:
  - Registers wr_en=1, wr_addr=count, wr_data=in_data.
  - Adds in_data to checksum, then increments count.
- LOAD, no handshake: wr_en=0 next cycle.
- Handshake with count == len-1 (last word):
  - Go to DONE if len == DEPTH.
  - Otherwise go to FILL.
- FILL: each cycle registers a write of wr_data=0 to wr_addr=count, then increments count. When count == DEPTH-1 is written, go to DONE.
- DONE: lasts one cycle.
  - cpu_rst=0 in this cycle.
  - Then go to IDLE.
  - cpu_rst stays 0 until the next accepted start or rst.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; nothing is consumed.
- Every address 0..DEPTH-1 is written exactly once per successful load, in ascending order, with no wrap.
- Zero fill does not change checksum. checksum holds its final value until the next accepted start.

## Timing
- wr_en/wr_addr/wr_data are registered and appear the cycle after the handshake or FILL cycle that produced them.
- DONE is entered on the same edge as the final write is registered, so done, cpu_rst falling and the final wr_en coincide.
- Accepted start in cycle 0 gives:
  - LOAD from cycle 1.
  - With no stalls, handshakes in cycles 1..len.
  - FILL in cycles len+1..DEPTH.
  - done in cycle DEPTH+1, independent of len.
- Each cycle with in_valid=0 in LOAD adds exactly one cycle of latency.
- rst mid-load:
  - All outputs return to reset values on the next edge.
  - No further writes; memory keeps only the words already written.
  - cpu_rst stays 1.
- rst and start in the same cycle: rst wins.

## Test plan
- Full load: rst, then start with len=16, 16 back-to-back words 0x10..0x1F.
  - wr_en in cycles 2..17 with addresses 0..15 and matching data.
  - done and cpu_rst=0 in cycle 17; checksum=0x78.
- Partial load with fill: start with len=5, words 0x81,0x42,0x03,0xC4,0x05.
  - Addresses 0..4 receive those words; addresses 5..15 receive 0x00.
  - done in cycle 17; checksum=0x8F.
- Stalls: len=3 with in_valid low for 2 cycles between each word.
  - in_ready high throughout LOAD; exactly 3 data writes.
  - done 4 cycles later than the unstalled case.
- Illegal length: start with len=0, then start with len=17.
  - err=1 after each; no wr_en; busy stays 0; cpu_rst stays 1.
  - A following legal start clears err.
- Reset mid-load: rst asserted after the 3rd handshake.
  - Next cycle: all outputs at reset values, cpu_rst=1, no further wr_en.
  - Extra in_valid pulses are not accepted.
- Ignored inputs: start pulses during LOAD/FILL, and in_valid during IDLE and FILL.
  - No effect on sequence, count or checksum.
  - Reload after a completed load raises cpu_rst the cycle after start.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction-memory program loader: streams words into addresses 0..len-1,
// zero-fills the rest, and holds the core in reset until the image is complete.
module prog_loader #(
    parameter int BIT_WIDTH  = 4,
    parameter int INST_WIDTH = BIT_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIT_WIDTH:0]    len,
    input  logic [INST_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [BIT_WIDTH-1:0]  wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [INST_WIDTH-1:0] checksum
);
    localparam int DEPTH = 2 ** BIT_WIDTH;
    localparam logic [BIT_WIDTH:0]   DEPTH_L   = (BIT_WIDTH + 1)'(DEPTH);
    localparam logic [BIT_WIDTH:0]   ONE_L     = (BIT_WIDTH + 1)'(1);
    localparam logic [BIT_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [BIT_WIDTH-1:0] ADDR_ONE  = BIT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [BIT_WIDTH-1:0]    count_q, count_d;
    logic [BIT_WIDTH:0]      len_q, len_d;
    logic                    wr_en_q, wr_en_d;
    logic [BIT_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [INST_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    err_q, err_d;
    logic [INST_WIDTH-1:0]   checksum_q, checksum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            len_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_rst_q  <= 1'b1;
            err_q      <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = err_q;
        checksum_d = checksum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= DEPTH_L) begin
                        state_d    = LOAD;
                        len_d      = len;
                        count_d    = '0;
                        checksum_d = '0;
                        err_d      = 1'b0;
                        cpu_rst_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = count_q;
                    wr_data_d  = in_data;
                    checksum_d = checksum_q + in_data;
                    count_d    = count_q + ADDR_ONE;
                    // A full-depth image has nothing left to zero-fill.
                    if ({1'b0, count_q} == len_q - ONE_L) begin
                        if (len_q == DEPTH_L) begin
                            state_d   = DONE;
                            cpu_rst_d = 1'b0;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q;
                wr_data_d = '0;
                count_d   = count_q + ADDR_ONE;
                if (count_q == LAST_ADDR) begin
                    state_d   = DONE;
                    cpu_rst_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign err      = err_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against an image/timing model.
module tb_prog_loader;
    localparam int BW    = 4;
    localparam int IW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW:0]   len;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [BW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] checksum;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [11:0]   wq[$];
    logic          cpu_rst_exp;

    always #5 clk = ~clk;

    prog_loader #(.BIT_WIDTH(BW), .INST_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and log any memory write visible in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en) wq.push_back({wr_addr, wr_data});
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_cpu_rst);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cpu_rst"}, cpu_rst, exp_cpu_rst);
    endtask

    // mode 0: back-to-back, 1: random stalls, 2: two idle cycles between words.
    task automatic do_load(input int L, input logic [7:0] w[16], input int mode,
                           input bit noise, output int done_t);
        int t = 1;
        int acc = 0;
        int stalls = 0;
        int gap = 0;
        int done_exp = 0;
        bit hs;
        bit loading;
        bit exp_wr = 1'b0;
        logic [7:0] sum = 8'h00;
        logic [7:0] expm[16];
        for (int i = 0; i < DEPTH; i++) begin
            expm[i] = (i < L) ? w[i] : 8'h00;
            if (i < L) sum += w[i];
        end
        wq.delete();
        done_t   = -1;
        start    = 1'b1;
        len      = 5'(L);
        in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        in_data  = 8'($urandom);
        tick();
        start = 1'b0;
        while (t <= 120) begin
            loading = (acc < L);
            if (!loading) done_exp = DEPTH + 1 + stalls;
            check("in_ready", in_ready, loading);
            check("wr_en", wr_en, exp_wr);
            check("busy", busy, 1);
            check("done", done, !loading && t == done_exp);
            check("cpu_rst", cpu_rst, !(!loading && t == done_exp));
            if (t == 1) check("err_clear", err, 0);
            if (!loading && t == done_exp) begin
                done_t = t;
                break;
            end
            if (loading) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = ($urandom_range(99) >= 30);
                    default: in_valid = (acc == 0) || (gap == 2);
                endcase
                in_data = w[acc];
            end else begin
                in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
                in_data  = 8'($urandom);
            end
            start = noise ? ($urandom_range(3) == 0) : 1'b0;
            len   = 5'($urandom_range(16, 1));
            hs = loading && in_valid;
            if (loading && !in_valid) begin
                stalls++;
                gap++;
            end
            if (hs) begin
                acc++;
                gap = 0;
            end
            exp_wr = hs || (!loading && t < done_exp);
            tick();
            t++;
        end
        if (done_t < 0) check("done_timeout", done_t, DEPTH + 1 + stalls);
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        cpu_rst_exp = 1'b0;
        check_idle_outputs("post", 1'b0);
        check("checksum", checksum, sum);
        check("n_writes", wq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < wq.size(); i++) begin
            check("w_addr", wq[i][11:8], i);
            check("w_data", wq[i][7:0], expm[i]);
        end
        $display("load len=%0d mode=%0d done_cycle=%0d checksum=%0h", L, mode, done_t, checksum);
    endtask

    task automatic illegal(input int L);
        start = 1'b1;
        len   = 5'(L);
        tick();
        start = 1'b0;
        check("ill_err", err, 1);
        check_idle_outputs("ill", cpu_rst_exp);
        tick();
        check_idle_outputs("ill2", cpu_rst_exp);
        $display("illegal len=%0d err=%0b busy=%0b", L, err, busy);
    endtask

    initial begin
        logic [7:0] w[16];
        int dt;
        int L;
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
        cpu_rst_exp = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("rst", 1'b1);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err", err, 0);
        check("rst_checksum", checksum, 0);
        $display("reset cpu_rst=%0b busy=%0b", cpu_rst, busy);

        illegal(0);
        illegal(17);

        for (int i = 0; i < 16; i++) w[i] = 8'(8'h10 + i);
        do_load(16, w, 0, 1'b0, dt);
        check("full_done_cycle", dt, 17);
        check("full_checksum", checksum, 8'h78);

        w[0] = 8'h81; w[1] = 8'h42; w[2] = 8'h03; w[3] = 8'hC4; w[4] = 8'h05;
        do_load(5, w, 0, 1'b1, dt);
        check("part_done_cycle", dt, 17);
        check("part_checksum", checksum, 8'h8F);

        for (int i = 0; i < 16; i++) w[i] = 8'($urandom);
        do_load(3, w, 2, 1'b0, dt);
        check("stall_done_cycle", dt, 21);

        illegal(0);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) w[i] = 8'($urandom);
            L = $urandom_range(16, 1);
            do_load(L, w, 1, 1'b1, dt);
        end

        // Reset after the third handshake of an 8-word load.
        wq.delete();
        start = 1'b1; len = 5'd8; in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_rst_exp = 1'b1;
        check_idle_outputs("midrst", 1'b1);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_checksum", checksum, 0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            tick();
            check_idle_outputs("midrst_after", 1'b1);
        end
        in_valid = 1'b0;
        check("midrst_n_writes", wq.size(), 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) check("midrst_w", wq[i], {4'(i), 8'(8'hA0 + i)});
        $display("midload reset writes=%0d cpu_rst=%0b", wq.size(), cpu_rst);

        rst = 1'b1; start = 1'b1; len = 5'd4;
        tick();
        rst = 1'b0; start = 1'b0;
        check_idle_outputs("rst_start", 1'b1);
        tick();
        check_idle_outputs("rst_start2", 1'b1);
        $display("rst+start busy=%0b", busy);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
